bit_modulator: RTL and testbench

- Transmit-side counterpart of the 1-bit filter/averaging receiver.
- Takes bytes over a valid/ready handshake and serialises each into a framed 1-bit stream: start symbol, 8 data symbols MSB-first, stop symbol.
- Every symbol is held for SAMPLES_PER_BIT clock cycles, so the receiver's averaging window spans one symbol.
- Sits between the byte source and the serial line driving the receiver's IN.

---
 rtl/bit_mod_pkg.sv | 23 ++
 rtl/bit_modulator_symbol_timer.sv | 37 +++
 rtl/bit_modulator.sv | 132 +++++++++++++
 tb/tb_bit_modulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_mod_pkg.sv
// Shared types and constants for the framed 1-bit modulator (bit_modulator).
// The MANCHESTER_EN macro selects Manchester-coded data symbols in the top.
package bit_mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b0;

    localparam int DEFAULT_DATA_W = 8;
    localparam int FRAME_SYMBOLS  = DEFAULT_DATA_W + 2;

    function automatic int frame_symbols(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/bit_modulator_symbol_timer.sv
// Per-symbol sample counter: counts 0..SAMPLES_PER_BIT-1 while enabled, held at 0 otherwise.
// Flags the first and last sample of a symbol and its second half.
module symbol_timer
    import bit_mod_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_first,
    output logic o_last,
    output logic o_half
);

    localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(SAMPLES_PER_BIT / 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == LAST_CNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_first = (r_cnt == '0);
    assign o_last  = (r_cnt == LAST_CNT);
    // High for the second half of the symbol; drives the Manchester inversion.
    assign o_half  = (r_cnt >= HALF_CNT);

endmodule

// File: rtl/bit_modulator.sv
// Byte-to-framed-serial modulator: start, DATA_W bits MSB-first, stop; each symbol SAMPLES_PER_BIT cycles.
// Define MANCHESTER_EN to invert each data symbol's second half (Manchester coding).
module bit_modulator
    import bit_mod_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 64,
    parameter int DATA_W          = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              OUT,
    output logic              BUSY,
    output logic              SYM_STROBE
);

    localparam int IDXW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(DATA_W - 1);
`ifdef MANCHESTER_EN
    localparam logic MANCH = 1'b1;
`else
    localparam logic MANCH = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_bit_idx;
    logic [IDXW-1:0]   w_bit_idx_nxt;
    logic [DATA_W-1:0] r_shift;
    logic              w_first;
    logic              w_last;
    logic              w_half;
    logic              w_active;
    logic              w_xfer;
    logic              w_level;
    logic              r_out_p1;
    logic              r_busy_p1;
    logic              r_strobe_p1;

    assign w_active  = (r_state != IDLE);
    assign DIN_READY = (r_state == IDLE) || ((r_state == STOP) && w_last);
    assign w_xfer    = DIN_VALID && DIN_READY;

    symbol_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_timer (
        .i_clk  (CLK),
        .i_rst_n(RST),
        .i_en   (w_active),
        .o_first(w_first),
        .o_last (w_last),
        .o_half (w_half)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
        end else if (w_xfer) begin
            r_shift <= DIN;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_level       = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_level = START_LEVEL;
                if (w_last) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = IDX_TOP;
                end
            end
            DATA: begin
                w_level = r_shift[r_bit_idx] ^ (MANCH & w_half);
                if (w_last) begin
                    if (r_bit_idx == '0) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - 1'b1;
                    end
                end
            end
            STOP: begin
                w_level = STOP_LEVEL;
                // A transfer on the last stop sample chains straight into the next frame.
                if (w_last) begin
                    w_state_nxt = w_xfer ? START : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output stage: registered view of the current symbol, one cycle behind the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_p1    <= 1'b0;
            r_busy_p1   <= 1'b0;
            r_strobe_p1 <= 1'b0;
        end else begin
            r_out_p1    <= w_level;
            r_busy_p1   <= w_active;
            r_strobe_p1 <= w_active && w_first;
        end
    end

    assign OUT        = r_out_p1;
    assign BUSY       = r_busy_p1;
    assign SYM_STROBE = r_strobe_p1;

endmodule

// File: tb/tb_bit_modulator.sv
// Directed bench for bit_modulator with SAMPLES_PER_BIT=4; expected waveforms are hand-built constants.
// Build with MANCHESTER_EN defined to select the Manchester-coded expectations.
module tb_bit_modulator;

    localparam int SPB = 4;
    localparam int DW  = 8;

`ifdef MANCHESTER_EN
    localparam logic [39:0] W_55 = 40'hF3C3C3C3C0;
    localparam logic [39:0] W_A5 = 40'hFC3C33C3C0;
    localparam logic [39:0] W_FF = 40'hFCCCCCCCC0;
    localparam logic [39:0] W_00 = 40'hF333333330;
    localparam logic [39:0] W_3C = 40'hF33CCCC330;
    localparam logic [39:0] W_C3 = 40'hFCC3333CC0;
    localparam logic [39:0] W_81 = 40'hFC333333C0;
    localparam logic [39:0] W_80 = 40'hFC33333330;
`else
    localparam logic [39:0] W_55 = 40'hF0F0F0F0F0;
    localparam logic [39:0] W_A5 = 40'hFF0F00F0F0;
    localparam logic [39:0] W_FF = 40'hFFFFFFFFF0;
    localparam logic [39:0] W_00 = 40'hF000000000;
    localparam logic [39:0] W_3C = 40'hF00FFFF000;
    localparam logic [39:0] W_C3 = 40'hFFF0000FF0;
    localparam logic [39:0] W_81 = 40'hFF000000F0;
    localparam logic [39:0] W_80 = 40'hFF00000000;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] DIN;
    logic          DIN_VALID;
    logic          DIN_READY;
    logic          OUT;
    logic          BUSY;
    logic          SYM_STROBE;

    always #5 CLK = ~CLK;

    bit_modulator #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_W         (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .OUT       (OUT),
        .BUSY      (BUSY),
        .SYM_STROBE(SYM_STROBE)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    bit            log_en = 1'b0;
    logic [3:0]    samp_q[$];
    int            acc_q[$];
    logic [DW-1:0] acc_d[$];

    // Sample log at each falling edge: {READY, STROBE, BUSY, OUT}; accepts noted at the sample preceding the edge.
    always @(negedge CLK) begin
        if (log_en) begin
            if (RST === 1'b1 && DIN_READY === 1'b1 && DIN_VALID === 1'b1) begin
                acc_q.push_back(samp_q.size());
                acc_d.push_back(DIN);
            end
            samp_q.push_back({DIN_READY, SYM_STROBE, BUSY, OUT});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wave(input int s, input int n);
        logic [63:0] w = '0;
        for (int i = 0; i < n; i++) begin
            if (s + i >= 0 && s + i < samp_q.size()) w = {w[62:0], samp_q[s+i][0]};
            else w = {w[62:0], 1'bx};
        end
        return w;
    endfunction

    function automatic int cnt(input int b, input int s, input int e);
        int c = 0;
        for (int i = s; i <= e; i++) begin
            if (i >= 0 && i < samp_q.size() && samp_q[i][b] === 1'b1) c++;
        end
        return c;
    endfunction

    task automatic clear_log();
        samp_q.delete();
        acc_q.delete();
        acc_d.delete();
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (DIN_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_ready_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d);
        @(posedge CLK); #1;
        DIN = d;
        DIN_VALID = 1'b1;
        wait_ready(tag);
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (45) @(negedge CLK);
    endtask

    task automatic check_frame(input string tag, input int a, input logic [39:0] exp);
        chk({tag, "_latency"}, wave(a + 1, 1), 64'd0);
        chk({tag, "_wave"}, wave(a + 2, 40), 64'(exp));
        chk({tag, "_busy"}, 64'(cnt(1, a + 2, a + 41)), 64'd40);
        chk({tag, "_strobes"}, 64'(cnt(2, a + 2, a + 41)), 64'd10);
        chk({tag, "_strobe0"}, 64'(cnt(2, a + 2, a + 2)), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low with a byte offered
        RST = 1'b0;
        DIN = 8'h55;
        DIN_VALID = 1'b1;
        log_en = 1'b1;
        repeat (6) @(negedge CLK);
        chk("rst_out", 64'(OUT), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_strobe", 64'(SYM_STROBE), 64'd0);
        chk("rst_ready", 64'(DIN_READY), 64'd1);
        chk("rst_no_busy", 64'(cnt(1, 0, samp_q.size() - 1)), 64'd0);
        chk("rst_no_accept", 64'(acc_q.size()), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        wait_ready("t1");
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (45) @(negedge CLK);
        chk("t1_accepts", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() >= 1) begin
            chk("t1_accept_idx", 64'(acc_q[0]), 64'd6);
            check_frame("t1", acc_q[0], W_55);
            chk("t1_idle_after", 64'(cnt(1, acc_q[0] + 42, acc_q[0] + 42)), 64'd0);
        end

        // Single frame 0xA5
        clear_log();
        send("t2", 8'hA5);
        chk("t2_accepts", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() >= 1) check_frame("t2", acc_q[0], W_A5);

        // Back-to-back 0xFF then 0x00
        clear_log();
        @(posedge CLK); #1;
        DIN = 8'hFF;
        DIN_VALID = 1'b1;
        wait_ready("t3a");
        @(posedge CLK); #1;
        DIN = 8'h00;
        wait_ready("t3b");
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (45) @(negedge CLK);
        chk("t3_accepts", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() >= 2) begin
            chk("t3_gap", 64'(acc_q[1] - acc_q[0]), 64'd40);
            chk("t3_data1", 64'(acc_d[1]), 64'h00);
            check_frame("t3a", acc_q[0], W_FF);
            check_frame("t3b", acc_q[1], W_00);
            chk("t3_busy_span", 64'(cnt(1, acc_q[0] + 2, acc_q[1] + 41)), 64'd80);
            chk("t3_ready_pulses", 64'(cnt(3, acc_q[0] + 1, acc_q[1])), 64'd1);
        end

        // DIN change during a frame
        clear_log();
        @(posedge CLK); #1;
        DIN = 8'h3C;
        DIN_VALID = 1'b1;
        wait_ready("t4a");
        @(posedge CLK); #1;
        DIN = 8'hC3;
        wait_ready("t4b");
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (45) @(negedge CLK);
        chk("t4_accepts", 64'(acc_q.size()), 64'd2);
        if (acc_q.size() >= 2) begin
            chk("t4_data0", 64'(acc_d[0]), 64'h3C);
            chk("t4_data1", 64'(acc_d[1]), 64'hC3);
            chk("t4_gap", 64'(acc_q[1] - acc_q[0]), 64'd40);
            check_frame("t4a", acc_q[0], W_3C);
            check_frame("t4b", acc_q[1], W_C3);
        end

        // Reset asserted in the fifth data symbol, then a clean 0x81 frame
        clear_log();
        @(posedge CLK); #1;
        DIN = 8'hFF;
        DIN_VALID = 1'b1;
        wait_ready("t5");
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (22) @(posedge CLK);
        #1;
        chk("t5_pre_out", 64'(OUT), 64'd1);
        chk("t5_pre_busy", 64'(BUSY), 64'd1);
        RST = 1'b0;
        #1;
        chk("t5_abort_out", 64'(OUT), 64'd0);
        chk("t5_abort_busy", 64'(BUSY), 64'd0);
        chk("t5_abort_ready", 64'(DIN_READY), 64'd1);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        clear_log();
        send("t5b", 8'h81);
        chk("t5_accepts", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() >= 1) check_frame("t5b", acc_q[0], W_81);

        // Single frame 0x80 (first data bit differs from the rest)
        clear_log();
        send("t6", 8'h80);
        chk("t6_accepts", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() >= 1) check_frame("t6", acc_q[0], W_80);

        log_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
